// File: rtl/gz_power_detector.sv
// Goertzel bin power detector: |Xk|^2 pipeline, band test and persistence hysteresis,
// emitting one 128-bit status word per accepted bin result.
module gz_power_detector #(
  parameter int          SW        = 16,
  parameter logic [32:0] LOWER     = 33'd65_028_096,
  parameter logic [32:0] UPPER     = 33'd67_108_864,
  parameter int          HOLD_N    = 4,
  parameter int          RELEASE_N = 4
) (
  input  logic            aclk,
  input  logic            arst,
  input  logic [2*SW-1:0] s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [127:0]    m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            signal_detected,
  output logic [15:0]     window_count
);

  localparam int PW = 2 * SW;
  localparam int MW = 2 * SW + 1;
  localparam logic [7:0] HOLD_L    = 8'(HOLD_N);
  localparam logic [7:0] RELEASE_L = 8'(RELEASE_N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_DETECTED,
    ST_RELEASING
  } state_t;

  logic                 advance;
  logic                 in_hs;

  logic                 v1_q, v2_q, out_valid_q;
  logic signed [PW-1:0] p_re_q, p_im_q;
  logic [15:0]          seq1_q, seq2_q;
  logic [MW-1:0]        mag_q;
  logic [127:0]         word_q;
  logic [15:0]          window_count_q;
  state_t               state_q;
  logic [7:0]           run_q;
  logic                 det_q;

  logic signed [SW-1:0] re_in, im_in;
  logic signed [PW-1:0] p_re_d, p_im_d;
  logic [MW-1:0]        mag_d;
  logic                 in_band;
  state_t               state_d;
  logic [7:0]           run_d;
  logic                 det_d;
  logic [127:0]         word_d;
  logic [7:0]           run_inc;

  // The whole pipeline moves in lockstep; only an unaccepted output word stalls it.
  assign advance       = ~(out_valid_q & ~m_axis_tready);
  assign in_hs         = s_axis_tvalid & advance;
  assign s_axis_tready = advance;

  assign m_axis_tdata    = word_q;
  assign m_axis_tvalid   = out_valid_q;
  assign signal_detected = det_q;
  assign window_count    = window_count_q;

  always_comb begin
    re_in  = signed'(s_axis_tdata[2*SW-1:SW]);
    im_in  = signed'(s_axis_tdata[SW-1:0]);
    p_re_d = re_in * re_in;
    p_im_d = im_in * im_in;
    // Squares are non-negative, so zero-extension before the add cannot overflow.
    mag_d  = {1'b0, p_re_q} + {1'b0, p_im_q};
  end

  assign in_band = (33'(mag_q) > LOWER) && (33'(mag_q) < UPPER);
  assign run_inc = run_q + 8'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    det_d   = det_q;
    case (state_q)
      ST_IDLE: begin
        if (in_band) begin
          if (HOLD_L == 8'd1) begin
            state_d = ST_DETECTED;
            det_d   = 1'b1;
          end else begin
            state_d = ST_ARMING;
            run_d   = 8'd1;
          end
        end
      end
      ST_ARMING: begin
        if (in_band) begin
          if (run_inc == HOLD_L) begin
            state_d = ST_DETECTED;
            run_d   = 8'd0;
            det_d   = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end else begin
          state_d = ST_IDLE;
          run_d   = 8'd0;
        end
      end
      ST_DETECTED: begin
        if (!in_band) begin
          if (RELEASE_L == 8'd1) begin
            state_d = ST_IDLE;
            det_d   = 1'b0;
          end else begin
            state_d = ST_RELEASING;
            run_d   = 8'd1;
          end
        end
      end
      ST_RELEASING: begin
        if (!in_band) begin
          if (run_inc == RELEASE_L) begin
            state_d = ST_IDLE;
            run_d   = 8'd0;
            det_d   = 1'b0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          state_d = ST_DETECTED;
          run_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = 8'd0;
        det_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    word_d         = '0;
    word_d[32:0]   = 33'(mag_q);
    word_d[33]     = in_band;
    word_d[34]     = det_d;
    word_d[63:48]  = seq2_q;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      out_valid_q    <= 1'b0;
      p_re_q         <= '0;
      p_im_q         <= '0;
      seq1_q         <= '0;
      seq2_q         <= '0;
      mag_q          <= '0;
      word_q         <= '0;
      window_count_q <= '0;
      state_q        <= ST_IDLE;
      run_q          <= '0;
      det_q          <= 1'b0;
    end else if (advance) begin
      v1_q        <= s_axis_tvalid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (in_hs) begin
        p_re_q         <= p_re_d;
        p_im_q         <= p_im_d;
        seq1_q         <= window_count_q;
        window_count_q <= window_count_q + 16'd1;
      end
      if (v1_q) begin
        mag_q  <= mag_d;
        seq2_q <= seq1_q;
      end
      // The FSM steps exactly once per result, on the edge that loads its status word.
      if (v2_q) begin
        word_q  <= word_d;
        state_q <= state_d;
        run_q   <= run_d;
        det_q   <= det_d;
      end
    end
  end

endmodule

// File: tb/tb_gz_power_detector.sv
// Directed self-checking bench for gz_power_detector: latency, band bounds,
// hysteresis, backpressure and mid-stream reset.
module tb_gz_power_detector;

  logic         aclk = 1'b0;
  logic         arst;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         signal_detected;
  logic [15:0]  window_count;

  int total = 0;
  int bad   = 0;

  logic [127:0] q_data[$];
  logic         q_det[$];

  gz_power_detector dut (
    .aclk            (aclk),
    .arst            (arst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .signal_detected (signal_detected),
    .window_count    (window_count)
  );

  always #5 aclk = ~aclk;

  // Output beats are captured on the falling edge; inputs only change just after rising edges.
  always @(negedge aclk) begin
    if (!arst && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_det.push_back(signal_detected);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    arst          = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    step();
    step();
    arst = 1'b0;
    q_data.delete();
    q_det.delete();
  endtask

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    s_axis_tdata  = {re, im};
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    for (int i = 0; i < 200 && q_data.size() < n; i++) step();
    check(tag, 64'(q_data.size()), 64'(n));
  endtask

  // Compares the i-th captured word against hand-computed fields.
  task automatic check_word(input int i, input logic [63:0] mag, input logic ib,
                            input logic det, input logic [15:0] seq);
    logic [127:0] w;
    if (i >= q_data.size()) begin
      check($sformatf("missing[%0d]", i), 64'(q_data.size()), 64'(i + 1));
    end else begin
      w = q_data[i];
      check($sformatf("mag[%0d]", i), 64'(w[32:0]), mag);
      check($sformatf("inband[%0d]", i), 64'(w[33]), 64'(ib));
      check($sformatf("det_bit[%0d]", i), 64'(w[34]), 64'(det));
      check($sformatf("det_port[%0d]", i), 64'(q_det[i]), 64'(det));
      check($sformatf("seq[%0d]", i), 64'(w[63:48]), 64'(seq));
      $display("word %0d: mag=%0d in_band=%0b det=%0b seq=%0d", i, w[32:0], w[33], w[34], w[63:48]);
    end
  endtask

  localparam logic [63:0] MAG_IN = 64'd65_610_000;

  initial begin
    bit pat[4];
    bit hys[16];
    bit det_exp[16];
    int k;
    logic stall, prev_stall, hs;
    logic [127:0] prev_data;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata_lo", m_axis_tdata[63:0], 64'd0);
    check("rst_tdata_hi", m_axis_tdata[127:64], 64'd0);
    check("rst_det", 64'(signal_detected), 64'd0);
    check("rst_wc", 64'(window_count), 64'd0);
    check("rst_sready", 64'(s_axis_tready), 64'd1);
    $display("reset: tvalid=%0b det=%0b wc=%0d", m_axis_tvalid, signal_detected, window_count);

    // Single beat latency: tvalid appears three edges after acceptance
    @(posedge aclk); #1;
    send(16'sd8100, 16'sd0);
    check("lat_c1", 64'(m_axis_tvalid), 64'd0);
    step();
    check("lat_c2", 64'(m_axis_tvalid), 64'd0);
    step();
    check("lat_c3", 64'(m_axis_tvalid), 64'd1);
    check("lat_mag", 64'(m_axis_tdata[32:0]), MAG_IN);
    check("lat_ib", 64'(m_axis_tdata[33]), 64'd1);
    check("lat_det", 64'(m_axis_tdata[34]), 64'd0);
    check("lat_pad", 64'(m_axis_tdata[47:35]), 64'd0);
    check("lat_seq", 64'(m_axis_tdata[63:48]), 64'd0);
    check("lat_hi", m_axis_tdata[127:64], 64'd0);
    check("lat_wc", 64'(window_count), 64'd1);
    $display("latency beat: mag=%0d in_band=%0b", m_axis_tdata[32:0], m_axis_tdata[33]);

    // Band bounds, sign independence, extreme magnitude
    do_reset();
    send(16'sd8064, 16'sd0);
    send(16'sd8192, 16'sd0);
    send(-16'sd8100, 16'sd0);
    send(-16'sd32768, -16'sd32768);
    wait_out(4, "bounds_count");
    check_word(0, 64'd65_028_096, 1'b0, 1'b0, 16'd0);
    check_word(1, 64'd67_108_864, 1'b0, 1'b0, 16'd1);
    check_word(2, MAG_IN, 1'b1, 1'b0, 16'd2);
    check_word(3, 64'd2_147_483_648, 1'b0, 1'b0, 16'd3);

    // Hysteresis: rises on the 8th result, falls on the 16th
    do_reset();
    hys     = '{1,1,1,0,1,1,1,1, 0,0,0,1,0,0,0,0};
    det_exp = '{0,0,0,0,0,0,0,1, 1,1,1,1,1,1,1,0};
    for (int i = 0; i < 16; i++) begin
      if (hys[i]) send(16'sd8100, 16'sd0);
      else        send(16'sd0, 16'sd0);
    end
    wait_out(16, "hys_count");
    for (int i = 0; i < 16; i++)
      check_word(i, hys[i] ? MAG_IN : 64'd0, hys[i], det_exp[i], 16'(i));

    // Backpressure: m_axis_tready cycles 1,0,0,1 while 10 in-band beats stream in
    do_reset();
    k = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 150 && (k < 10 || q_data.size() < 10); cyc++) begin
      m_axis_tready = pat[cyc % 4];
      s_axis_tvalid = (k < 10);
      s_axis_tdata  = {16'sd8100, 16'sd0};
      @(negedge aclk);
      stall = m_axis_tvalid & ~m_axis_tready;
      check($sformatf("bp_sready[%0d]", cyc), 64'(s_axis_tready), 64'(!stall));
      if (prev_stall) begin
        check($sformatf("bp_hold_valid[%0d]", cyc), 64'(m_axis_tvalid), 64'd1);
        check($sformatf("bp_hold_data[%0d]", cyc), m_axis_tdata[63:0], prev_data[63:0]);
      end
      hs         = s_axis_tvalid & s_axis_tready;
      prev_stall = stall;
      prev_data  = m_axis_tdata;
      step();
      if (hs) k++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    check("bp_accepted", 64'(k), 64'd10);
    check("bp_count", 64'(q_data.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      check_word(i, MAG_IN, 1'b1, (i >= 3), 16'(i));
    check("bp_wc", 64'(window_count), 64'd10);

    // Reset mid-stream: in-flight results vanish, the held handshake is not counted
    do_reset();
    send(16'sd8100, 16'sd0);
    send(16'sd8100, 16'sd0);
    s_axis_tdata  = {16'sd8100, 16'sd0};
    s_axis_tvalid = 1'b1;
    arst          = 1'b1;
    step();
    check("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mrst_det", 64'(signal_detected), 64'd0);
    check("mrst_wc", 64'(window_count), 64'd0);
    check("mrst_leak", 64'(q_data.size()), 64'd0);
    arst          = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    q_data.delete();
    q_det.delete();
    for (int i = 0; i < 4; i++) send(16'sd8100, 16'sd0);
    wait_out(4, "mrst_count");
    for (int i = 0; i < 4; i++)
      check_word(i, MAG_IN, 1'b1, (i == 3), 16'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
